ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_if.sv | 30 +++
 rtl/ctrl_pipe.sv | 83 ++++++++
 2 files changed

// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between the ID-stage decoder/hazard unit and the control pipeline.
// The pipeline sits on the slave side; the driver of ID controls uses master.
interface ctrl_pipe_if;
    logic       valid_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID;
    logic [4:0] rs1n_ID, rs2n_ID, rdn_ID;
    logic       load_stall, branch_taken_EX, mem_ready, cnt_clr;

    logic [4:0] registerNumber1_EX, registerNumber2_EX, rdn_EX, rdn_MEM, rdn_WB;
    logic       MemToReg_EX, RegWrite_MEM, MemToReg_MEM, RegWrite_WB, MemToReg_WB;
    logic       Stall_IF, Stall_ID, Flush_ID, freeze, retire;
    logic [15:0] bubble_cnt;

    modport slave (
        input  valid_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID,
        input  rs1n_ID, rs2n_ID, rdn_ID,
        input  load_stall, branch_taken_EX, mem_ready, cnt_clr,
        output registerNumber1_EX, registerNumber2_EX, rdn_EX, rdn_MEM, rdn_WB,
        output MemToReg_EX, RegWrite_MEM, MemToReg_MEM, RegWrite_WB, MemToReg_WB,
        output Stall_IF, Stall_ID, Flush_ID, freeze, retire, bubble_cnt
    );

    modport master (
        output valid_ID, RegWrite_ID, MemToReg_ID, MemWrite_ID,
        output rs1n_ID, rs2n_ID, rdn_ID,
        output load_stall, branch_taken_EX, mem_ready, cnt_clr,
        input  registerNumber1_EX, registerNumber2_EX, rdn_EX, rdn_MEM, rdn_WB,
        input  MemToReg_EX, RegWrite_MEM, MemToReg_MEM, RegWrite_WB, MemToReg_WB,
        input  Stall_IF, Stall_ID, Flush_ID, freeze, retire, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with stall, flush, memory freeze,
// retire pulse and a saturating bubble counter.
module ctrl_pipe (
    input  logic        clk,
    input  logic        reset,
    ctrl_pipe_if.slave  bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1n;
        logic [4:0] rs2n;
        logic [4:0] rdn;
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
    } stage_t;

    stage_t      r_idex, r_exmem, r_memwb;
    stage_t      w_id;
    logic        r_retire;
    logic [15:0] r_bubble_cnt;
    logic        w_freeze, w_id_bubble, w_count;

    always_comb begin
        w_id          = '0;
        w_id.valid    = bus.valid_ID;
        w_id.rs1n     = bus.rs1n_ID;
        w_id.rs2n     = bus.rs2n_ID;
        w_id.rdn      = bus.rdn_ID;
        w_id.RegWrite = bus.RegWrite_ID;
        w_id.MemToReg = bus.MemToReg_ID;
        w_id.MemWrite = bus.MemWrite_ID;
    end

    // A memory op parked in MEM holds the back end until the data memory answers.
    assign w_freeze    = r_exmem.valid & (r_exmem.MemToReg | r_exmem.MemWrite) & ~bus.mem_ready;
    assign w_id_bubble = bus.load_stall | bus.branch_taken_EX;
    assign w_count     = w_freeze | bus.load_stall | bus.branch_taken_EX;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else if (w_freeze) begin
            r_memwb <= '0;
        end else begin
            r_memwb <= r_exmem;
            r_exmem <= r_idex;
            r_idex  <= w_id_bubble ? '0 : w_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire     <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            r_retire <= r_memwb.valid;
            if (bus.cnt_clr)
                r_bubble_cnt <= '0;
            else if (w_count && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.registerNumber1_EX = r_idex.rs1n;
    assign bus.registerNumber2_EX = r_idex.rs2n;
    assign bus.rdn_EX             = r_idex.rdn;
    assign bus.rdn_MEM            = r_exmem.rdn;
    assign bus.rdn_WB             = r_memwb.rdn;
    assign bus.MemToReg_EX        = r_idex.valid  & r_idex.MemToReg;
    assign bus.RegWrite_MEM       = r_exmem.valid & r_exmem.RegWrite;
    assign bus.MemToReg_MEM       = r_exmem.valid & r_exmem.MemToReg;
    assign bus.RegWrite_WB        = r_memwb.valid & r_memwb.RegWrite;
    assign bus.MemToReg_WB        = r_memwb.valid & r_memwb.MemToReg;
    assign bus.Stall_IF           = w_freeze | bus.load_stall;
    assign bus.Stall_ID           = w_freeze | bus.load_stall;
    assign bus.Flush_ID           = bus.branch_taken_EX & ~w_freeze;
    assign bus.freeze             = w_freeze;
    assign bus.retire             = r_retire;
    assign bus.bubble_cnt         = r_bubble_cnt;
endmodule
